// File: rtl/ccip_host_mem_responder.sv
// CCI-P host-memory stand-in: per-channel request FIFOs, round-robin issue into a
// single-port line RAM, read responses after a 3-stage pipe and write acks after one.
module ccip_host_mem_responder #(
  parameter int ADDR_WIDTH      = 42,
  parameter int MDATA_WIDTH     = 16,
  parameter int MEM_LINES_LOG2  = 10,
  parameter int FIFO_DEPTH_LOG2 = 5,
  parameter int ALMFULL_SLACK   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   c0_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c0_req_addr,
  input  logic [MDATA_WIDTH-1:0] c0_req_mdata,
  input  logic                   c1_req_valid,
  input  logic [ADDR_WIDTH-1:0]  c1_req_addr,
  input  logic [MDATA_WIDTH-1:0] c1_req_mdata,
  input  logic [511:0]           c1_req_data,
  output logic                   c0_almfull,
  output logic                   c1_almfull,
  output logic                   c0_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c0_rsp_mdata,
  output logic [511:0]           c0_rsp_data,
  output logic                   c1_rsp_valid,
  output logic [MDATA_WIDTH-1:0] c1_rsp_mdata,
  output logic                   err_overflow,
  output logic                   err_oob
);
  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;
  localparam int LINES = 2 ** MEM_LINES_LOG2;
  localparam int PW    = FIFO_DEPTH_LOG2;
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0] AF_CNT   = (PW+1)'(DEPTH - ALMFULL_SLACK);

  logic [ADDR_WIDTH-1:0]  c0_fifo_addr_q  [DEPTH];
  logic [MDATA_WIDTH-1:0] c0_fifo_mdata_q [DEPTH];
  logic [ADDR_WIDTH-1:0]  c1_fifo_addr_q  [DEPTH];
  logic [MDATA_WIDTH-1:0] c1_fifo_mdata_q [DEPTH];
  logic [511:0]           c1_fifo_data_q  [DEPTH];
  logic [511:0]           mem_q           [LINES];
  logic [511:0]           ram_rdata_q;

  logic [PW-1:0] c0_wptr_q, c0_wptr_d, c0_rptr_q, c0_rptr_d;
  logic [PW-1:0] c1_wptr_q, c1_wptr_d, c1_rptr_q, c1_rptr_d;
  logic [PW:0]   c0_cnt_q, c0_cnt_d, c1_cnt_q, c1_cnt_d;
  logic          rr_q, rr_d;
  logic          c0_almfull_q, c0_almfull_d, c1_almfull_q, c1_almfull_d;
  logic          err_overflow_q, err_overflow_d, err_oob_q, err_oob_d;
  logic          rd1_v_q, rd1_v_d, rd1_oob_q, rd1_oob_d, rd2_v_q, rd2_v_d;
  logic [MDATA_WIDTH-1:0] rd1_mdata_q, rd1_mdata_d, rd2_mdata_q, rd2_mdata_d;
  logic [511:0]  rd2_data_q, rd2_data_d;
  logic          c0_rsp_valid_q, c0_rsp_valid_d, c1_rsp_valid_q, c1_rsp_valid_d;
  logic [MDATA_WIDTH-1:0] c0_rsp_mdata_q, c0_rsp_mdata_d, c1_rsp_mdata_q, c1_rsp_mdata_d;
  logic [511:0]  c0_rsp_data_q, c0_rsp_data_d;

  logic c0_head_v_s, c1_head_v_s, gnt0_s, gnt1_s, c0_enq_s, c1_enq_s, mem_we_s;
  logic c0_head_oob_s, c1_head_oob_s;
  logic [ADDR_WIDTH-1:0]  c0_head_addr_s, c1_head_addr_s;
  logic [MDATA_WIDTH-1:0] c0_head_mdata_s, c1_head_mdata_s;

  // Head decode and arbitration; rr_q=0 favours c0 when both heads are waiting.
  always_comb begin
    c0_head_v_s     = (c0_cnt_q != '0);
    c1_head_v_s     = (c1_cnt_q != '0);
    gnt0_s          = c0_head_v_s && (!c1_head_v_s || !rr_q);
    gnt1_s          = c1_head_v_s && !gnt0_s;
    // A full FIFO still accepts when its head leaves in the same cycle.
    c0_enq_s        = c0_req_valid && ((c0_cnt_q != FULL_CNT) || gnt0_s);
    c1_enq_s        = c1_req_valid && ((c1_cnt_q != FULL_CNT) || gnt1_s);
    c0_head_addr_s  = c0_fifo_addr_q[c0_rptr_q];
    c1_head_addr_s  = c1_fifo_addr_q[c1_rptr_q];
    c0_head_mdata_s = c0_fifo_mdata_q[c0_rptr_q];
    c1_head_mdata_s = c1_fifo_mdata_q[c1_rptr_q];
    c0_head_oob_s   = |c0_head_addr_s[ADDR_WIDTH-1:MEM_LINES_LOG2];
    c1_head_oob_s   = |c1_head_addr_s[ADDR_WIDTH-1:MEM_LINES_LOG2];
    mem_we_s        = gnt1_s && !c1_head_oob_s && !reset;
  end

  always_comb begin
    c0_wptr_d      = c0_wptr_q + PW'(c0_enq_s);
    c0_rptr_d      = c0_rptr_q + PW'(gnt0_s);
    c0_cnt_d       = c0_cnt_q + (PW+1)'(c0_enq_s) - (PW+1)'(gnt0_s);
    c1_wptr_d      = c1_wptr_q + PW'(c1_enq_s);
    c1_rptr_d      = c1_rptr_q + PW'(gnt1_s);
    c1_cnt_d       = c1_cnt_q + (PW+1)'(c1_enq_s) - (PW+1)'(gnt1_s);
    rr_d           = gnt0_s ? 1'b1 : (gnt1_s ? 1'b0 : rr_q);
    c0_almfull_d   = (c0_cnt_d >= AF_CNT);
    c1_almfull_d   = (c1_cnt_d >= AF_CNT);
    err_overflow_d = err_overflow_q | (c0_req_valid & ~c0_enq_s) | (c1_req_valid & ~c1_enq_s);
    err_oob_d      = err_oob_q | (gnt0_s & c0_head_oob_s) | (gnt1_s & c1_head_oob_s);
    rd1_v_d        = gnt0_s;
    rd1_oob_d      = gnt0_s & c0_head_oob_s;
    rd1_mdata_d    = gnt0_s ? c0_head_mdata_s : rd1_mdata_q;
    rd2_v_d        = rd1_v_q;
    rd2_mdata_d    = rd1_mdata_q;
    rd2_data_d     = (rd1_v_q && !rd1_oob_q) ? ram_rdata_q : 512'd0;
    c0_rsp_valid_d = rd2_v_q;
    c0_rsp_mdata_d = rd2_mdata_q;
    c0_rsp_data_d  = rd2_data_q;
    c1_rsp_valid_d = gnt1_s;
    c1_rsp_mdata_d = gnt1_s ? c1_head_mdata_s : c1_rsp_mdata_q;
  end

  // Storage: FIFO entries, line RAM and its registered read port (not reset).
  always_ff @(posedge clk) begin
    if (c0_enq_s) begin
      c0_fifo_addr_q[c0_wptr_q]  <= c0_req_addr;
      c0_fifo_mdata_q[c0_wptr_q] <= c0_req_mdata;
    end
    if (c1_enq_s) begin
      c1_fifo_addr_q[c1_wptr_q]  <= c1_req_addr;
      c1_fifo_mdata_q[c1_wptr_q] <= c1_req_mdata;
      c1_fifo_data_q[c1_wptr_q]  <= c1_req_data;
    end
    if (mem_we_s) begin
      mem_q[c1_head_addr_s[MEM_LINES_LOG2-1:0]] <= c1_fifo_data_q[c1_rptr_q];
    end
    if (gnt0_s) begin
      ram_rdata_q <= mem_q[c0_head_addr_s[MEM_LINES_LOG2-1:0]];
    end
  end

  // Control and pipeline state.
  always_ff @(posedge clk) begin
    if (reset) begin
      c0_wptr_q      <= '0;
      c0_rptr_q      <= '0;
      c0_cnt_q       <= '0;
      c1_wptr_q      <= '0;
      c1_rptr_q      <= '0;
      c1_cnt_q       <= '0;
      rr_q           <= 1'b0;
      c0_almfull_q   <= 1'b0;
      c1_almfull_q   <= 1'b0;
      err_overflow_q <= 1'b0;
      err_oob_q      <= 1'b0;
      rd1_v_q        <= 1'b0;
      rd1_oob_q      <= 1'b0;
      rd1_mdata_q    <= '0;
      rd2_v_q        <= 1'b0;
      rd2_mdata_q    <= '0;
      rd2_data_q     <= 512'd0;
      c0_rsp_valid_q <= 1'b0;
      c0_rsp_mdata_q <= '0;
      c0_rsp_data_q  <= 512'd0;
      c1_rsp_valid_q <= 1'b0;
      c1_rsp_mdata_q <= '0;
    end else begin
      c0_wptr_q      <= c0_wptr_d;
      c0_rptr_q      <= c0_rptr_d;
      c0_cnt_q       <= c0_cnt_d;
      c1_wptr_q      <= c1_wptr_d;
      c1_rptr_q      <= c1_rptr_d;
      c1_cnt_q       <= c1_cnt_d;
      rr_q           <= rr_d;
      c0_almfull_q   <= c0_almfull_d;
      c1_almfull_q   <= c1_almfull_d;
      err_overflow_q <= err_overflow_d;
      err_oob_q      <= err_oob_d;
      rd1_v_q        <= rd1_v_d;
      rd1_oob_q      <= rd1_oob_d;
      rd1_mdata_q    <= rd1_mdata_d;
      rd2_v_q        <= rd2_v_d;
      rd2_mdata_q    <= rd2_mdata_d;
      rd2_data_q     <= rd2_data_d;
      c0_rsp_valid_q <= c0_rsp_valid_d;
      c0_rsp_mdata_q <= c0_rsp_mdata_d;
      c0_rsp_data_q  <= c0_rsp_data_d;
      c1_rsp_valid_q <= c1_rsp_valid_d;
      c1_rsp_mdata_q <= c1_rsp_mdata_d;
    end
  end

  assign c0_almfull   = c0_almfull_q;
  assign c1_almfull   = c1_almfull_q;
  assign c0_rsp_valid = c0_rsp_valid_q;
  assign c0_rsp_mdata = c0_rsp_mdata_q;
  assign c0_rsp_data  = c0_rsp_data_q;
  assign c1_rsp_valid = c1_rsp_valid_q;
  assign c1_rsp_mdata = c1_rsp_mdata_q;
  assign err_overflow = err_overflow_q;
  assign err_oob      = err_oob_q;

endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Directed bench for ccip_host_mem_responder: table of single transactions with
// exact-latency checks, plus hand-written backpressure, arbitration and reset sequences.
module tb_ccip_host_mem_responder;
  logic         clk = 1'b0;
  logic         reset;
  logic         c0_req_valid, c1_req_valid;
  logic [41:0]  c0_req_addr, c1_req_addr;
  logic [15:0]  c0_req_mdata, c1_req_mdata;
  logic [511:0] c1_req_data;
  logic         c0_almfull, c1_almfull, c0_rsp_valid, c1_rsp_valid, err_overflow, err_oob;
  logic [15:0]  c0_rsp_mdata, c1_rsp_mdata;
  logic [511:0] c0_rsp_data;

  int n_vec = 0;
  int n_bad = 0;
  logic [15:0] c0_got[$];
  int c1_got = 0;

  always #5 clk = ~clk;

  ccip_host_mem_responder dut (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_req_valid), .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c1_req_valid(c1_req_valid), .c1_req_addr(c1_req_addr), .c1_req_mdata(c1_req_mdata),
    .c1_req_data(c1_req_data),
    .c0_almfull(c0_almfull), .c1_almfull(c1_almfull),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata), .c0_rsp_data(c0_rsp_data),
    .c1_rsp_valid(c1_rsp_valid), .c1_rsp_mdata(c1_rsp_mdata),
    .err_overflow(err_overflow), .err_oob(err_oob)
  );

  // Response monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (c0_rsp_valid === 1'b1) c0_got.push_back(c0_rsp_mdata);
    if (c1_rsp_valid === 1'b1) c1_got++;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    c0_req_valid = 1'b0; c1_req_valid = 1'b0;
    c0_req_addr = 42'd0; c1_req_addr = 42'd0;
    c0_req_mdata = 16'd0; c1_req_mdata = 16'd0; c1_req_data = 512'd0;
  endtask

  task automatic do_reset();
    @(negedge clk); idle_inputs(); reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Drive one cycle of traffic ahead of the next rising edge.
  task automatic drive(input logic rv, input logic [41:0] ra, input logic [15:0] rm,
                       input logic wv, input logic [41:0] wa, input logic [15:0] wm);
    @(negedge clk);
    c0_req_valid = rv; c0_req_addr = ra; c0_req_mdata = rm;
    c1_req_valid = wv; c1_req_addr = wa; c1_req_mdata = wm;
    c1_req_data = {16{16'hC0DE, wm}};
  endtask

  task automatic drain(input int cycles);
    @(negedge clk); idle_inputs();
    repeat (cycles) @(negedge clk);
  endtask

  typedef struct {
    logic         wr;
    logic [41:0]  addr;
    logic [15:0]  mdata;
    logic [511:0] data;
    logic [511:0] exp_data;
    logic         exp_oob;
  } vec_t;

  vec_t vecs[10];

  task automatic apply_vec(input vec_t v, input int idx);
    string nm;
    @(negedge clk);
    if (v.wr) begin
      c1_req_valid = 1'b1; c1_req_addr = v.addr; c1_req_mdata = v.mdata; c1_req_data = v.data;
    end else begin
      c0_req_valid = 1'b1; c0_req_addr = v.addr; c0_req_mdata = v.mdata;
    end
    // k-th falling edge after the sampling edge T: write ack at k=1, read data at k=3.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      idle_inputs();
      if (v.wr) begin
        nm = $sformatf("v%0d_c1_valid_k%0d", idx, k);
        check(nm, {511'd0, c1_rsp_valid}, {511'd0, (k == 1)});
        if (k == 1) check($sformatf("v%0d_c1_mdata", idx), {496'd0, c1_rsp_mdata}, {496'd0, v.mdata});
      end else begin
        nm = $sformatf("v%0d_c0_valid_k%0d", idx, k);
        check(nm, {511'd0, c0_rsp_valid}, {511'd0, (k == 3)});
        if (k == 3) begin
          check($sformatf("v%0d_c0_mdata", idx), {496'd0, c0_rsp_mdata}, {496'd0, v.mdata});
          check($sformatf("v%0d_c0_data", idx), c0_rsp_data, v.exp_data);
        end
      end
    end
    check($sformatf("v%0d_err_oob", idx), {511'd0, err_oob}, {511'd0, v.exp_oob});
    check($sformatf("v%0d_err_ovf", idx), {511'd0, err_overflow}, 512'd0);
  endtask

  initial begin
    int n0, n1, pc1;
    logic [511:0] pa, pb, pc;
    pa = {64{8'hA5}};
    pb = {16{32'hDEADBEEF}};
    pc = {8{64'h0123456789ABCDEF}};
    vecs[0] = '{1'b1, 42'h005,           16'h0011, pa,            512'd0, 1'b0};
    vecs[1] = '{1'b0, 42'h005,           16'h0022, 512'd0,        pa,     1'b0};
    vecs[2] = '{1'b1, 42'h3FF,           16'h0033, pb,            512'd0, 1'b0};
    vecs[3] = '{1'b0, 42'h3FF,           16'h0034, 512'd0,        pb,     1'b0};
    vecs[4] = '{1'b1, 42'h000,           16'h0036, pc,            512'd0, 1'b0};
    vecs[5] = '{1'b0, 42'h000,           16'h0037, 512'd0,        pc,     1'b0};
    vecs[6] = '{1'b0, 42'h400,           16'h0040, 512'd0,        512'd0, 1'b1};
    vecs[7] = '{1'b1, 42'h400,           16'h0041, {64{8'hFF}},   512'd0, 1'b1};
    vecs[8] = '{1'b0, 42'h000,           16'h0042, 512'd0,        pc,     1'b1};
    vecs[9] = '{1'b0, 42'h200_0000_0000, 16'h0043, 512'd0,        512'd0, 1'b1};

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_outputs", {503'd0, c0_almfull, c1_almfull, c0_rsp_valid, c1_rsp_valid,
          err_overflow, err_oob, |c0_rsp_mdata, |c1_rsp_mdata, |c0_rsp_data}, 512'd0);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) apply_vec(vecs[i], i);

    // Mid-operation reset with reads queued behind a write stream.
    for (int e = 0; e < 20; e++) drive(1'b1, 42'(e), 16'(e), 1'b1, 42'(600 + e), 16'(e));
    @(negedge clk); idle_inputs(); reset = 1'b1;
    check("pre_rst_oob", {511'd0, err_oob}, {511'd0, 1'b1});
    @(negedge clk);
    c0_got.delete(); c1_got = 0;
    @(negedge clk); reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_c0_rsp", 512'(c0_got.size()), 512'd0);
    check("rst_no_c1_rsp", 512'(c1_got), 512'd0);
    check("rst_flags", {508'd0, c0_almfull, c1_almfull, err_oob, err_overflow}, 512'd0);

    // Almfull: reads stalled by interleaved writes; c0 count after edge e is e/2+1.
    do_reset(); c0_got.delete(); c1_got = 0;
    for (int e = 0; e < 47; e++) begin
      drive(1'b1, 42'(e), 16'(e), 1'b1, 42'(700 + e), 16'(e));
      @(posedge clk); #1;
      if (e >= 44) check($sformatf("almfull_e%0d", e), {511'd0, c0_almfull}, {511'd0, (e >= 46)});
    end
    drain(120);
    check("af_no_ovf", {511'd0, err_overflow}, 512'd0);
    check("af_rsp_count", 512'(c0_got.size()), 512'd47);
    for (int i = 0; i < 47 && i < c0_got.size(); i++)
      if (c0_got[i] !== 16'(i)) check($sformatf("af_order_%0d", i), {496'd0, c0_got[i]}, 512'(i));

    // Saturated arbitration: steady-state issues strictly alternate c0/c1.
    do_reset(); c0_got.delete(); c1_got = 0;
    n0 = 0; n1 = 0; pc1 = 0;
    for (int e = 0; e < 60; e++) begin
      drive(1'b1, 42'(e), 16'(e), 1'b1, 42'(800 + e), 16'(e));
      if (e >= 10 && e < 50) begin
        n0 += int'(c0_rsp_valid); n1 += int'(c1_rsp_valid);
        check($sformatf("arb_xor_e%0d", e), {511'd0, c0_rsp_valid ^ c1_rsp_valid}, {511'd0, 1'b1});
        if (e > 10) check($sformatf("arb_alt_e%0d", e), 512'(c1_rsp_valid), 512'(pc1 == 0));
        pc1 = int'(c1_rsp_valid);
      end
    end
    check("arb_share_c0", 512'((n0 >= 19) && (n0 <= 21)), 512'd1);
    check("arb_share_c1", 512'((n1 >= 19) && (n1 <= 21)), 512'd1);
    drain(150);
    check("arb_total_c0", 512'(c0_got.size()), 512'd60);
    check("arb_total_c1", 512'(c1_got), 512'd60);
    check("arb_no_ovf", {511'd0, err_overflow}, 512'd0);

    // Overflow: 65 reads, 63 writes; only the read sampled at edge 64 finds c0 full.
    do_reset(); c0_got.delete(); c1_got = 0;
    for (int e = 0; e < 65; e++)
      drive(1'b1, 42'(e), 16'(e), (e <= 62), 42'(512 + e), 16'(e));
    drain(200);
    check("ovf_flag", {511'd0, err_overflow}, {511'd0, 1'b1});
    check("ovf_rsp_count", 512'(c0_got.size()), 512'd64);
    check("ovf_c1_count", 512'(c1_got), 512'd63);
    for (int i = 0; i < 64 && i < c0_got.size(); i++)
      if (c0_got[i] !== 16'(i)) check($sformatf("ovf_order_%0d", i), {496'd0, c0_got[i]}, 512'(i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
